// File: rtl/mem_req_arbiter_pkg.sv
// Shared types for the processor-side memory request arbiter.
package mem_req_arbiter_pkg;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'b00,
    BUS_LOAD  = 2'b01,
    BUS_STORE = 2'b10
  } bus_cmd_t;

  typedef enum logic {
    MEM_CLIENT_IC = 1'b0,
    MEM_CLIENT_DC = 1'b1
  } mem_client_t;

  typedef struct packed {
    logic        vld;
    mem_client_t owner;
  } tag_ent_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

  localparam tag_ent_t TAG_ENT_EMPTY = '{vld: 1'b0, owner: MEM_CLIENT_IC};

endpackage

// File: rtl/mem_tag_table.sv
// Outstanding-load tag table: one entry per bus tag (tag 0 is never used).
// Allocate port writes an entry on load acceptance; the lookup port reports
// the owner of a returning tag and clears it when clr_en is asserted.
// A clear and an allocate of the same tag in one cycle leave the entry valid.
module mem_tag_table
  import mem_req_arbiter_pkg::*;
#(
  parameter int TAG_W   = 4,
  parameter int TAG_NUM = 15,
  parameter int CNT_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_en,
  input  logic [TAG_W-1:0]  alloc_tag,
  input  mem_client_t       alloc_owner,
  input  logic              clr_en,
  input  logic [TAG_W-1:0]  lk_tag,
  output logic              lk_vld,
  output mem_client_t       lk_owner,
  output logic [CNT_W-1:0]  outstanding
);

  tag_ent_t tbl [TAG_NUM+1];
  logic     alloc_ok, clr_ok;

  assign lk_vld   = (lk_tag != '0) && tbl[lk_tag].vld;
  assign lk_owner = tbl[lk_tag].owner;
  assign alloc_ok = alloc_en && (alloc_tag != '0);
  assign clr_ok   = clr_en && lk_vld;

  // Entry update: clear first, so a same-tag allocate wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i <= TAG_NUM; i++) tbl[i] <= TAG_ENT_EMPTY;
    end else begin
      if (clr_ok)   tbl[lk_tag]    <= TAG_ENT_EMPTY;
      if (alloc_ok) tbl[alloc_tag] <= '{vld: 1'b1, owner: alloc_owner};
    end
  end

  // Loads in flight; a same-cycle allocate and clear cancel out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   outstanding <= '0;
    else if (alloc_ok && !clr_ok) outstanding <= outstanding + CNT_W'(1);
    else if (clr_ok && !alloc_ok) outstanding <= outstanding - CNT_W'(1);
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Arbitrates icache loads and dcache loads/stores onto the tagged proc2mem bus,
// holds a refused request until accepted, and routes tagged returns back to
// the cache that issued the load.
// Build option MEM_ARB_RR_EN: alternate grants on ties (dcache first after
// reset); without it the dcache always wins ties.
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TAG_W   = 4,
  parameter int TAG_NUM = 15
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ic_req_i,
  input  logic [ADDR_W-1:0]            ic_addr_i,
  output logic                         ic_ack_o,
  output logic [TAG_W-1:0]             ic_ack_tag_o,
  output logic                         ic_rdata_vld_o,
  output logic [DATA_W-1:0]            ic_rdata_o,
  output logic [TAG_W-1:0]             ic_rtag_o,
  input  logic                         dc_req_i,
  input  logic                         dc_wr_i,
  input  logic [ADDR_W-1:0]            dc_addr_i,
  input  logic [DATA_W-1:0]            dc_wdata_i,
  output logic                         dc_ack_o,
  output logic [TAG_W-1:0]             dc_ack_tag_o,
  output logic                         dc_rdata_vld_o,
  output logic [DATA_W-1:0]            dc_rdata_o,
  output logic [TAG_W-1:0]             dc_rtag_o,
  output logic [1:0]                   proc2mem_command_o,
  output logic [ADDR_W-1:0]            proc2mem_addr_o,
  output logic [DATA_W-1:0]            proc2mem_data_o,
  input  logic [TAG_W-1:0]             mem2proc_response_i,
  input  logic [DATA_W-1:0]            mem2proc_data_i,
  input  logic [TAG_W-1:0]             mem2proc_tag_i,
  output logic [$clog2(TAG_NUM+1)-1:0] arb_outstanding_o,
  output logic                         arb_err_o
);

  localparam int CNT_W = $clog2(TAG_NUM+1);

  arb_state_t         state_q, state_d;
  mem_client_t        hold_cl_q;
  bus_cmd_t           hold_cmd_q;
  logic [ADDR_W-1:0]  hold_addr_q;
  logic [DATA_W-1:0]  hold_data_q;
  mem_client_t        tie_cl, sel_cl, lk_owner;
  bus_cmd_t           cmd;
  logic [ADDR_W-1:0]  addr;
  logic [DATA_W-1:0]  data;
  logic               sel_vld, accept, tag_full, ic_ok, dc_ok, lk_vld, ret_hit, err_q;
  logic [CNT_W-1:0]   outstanding;

  // Loads wait while every tag is in flight; stores never need a tag.
  assign tag_full = (outstanding == CNT_W'(TAG_NUM));
  assign ic_ok    = ic_req_i && !tag_full;
  assign dc_ok    = dc_req_i && (dc_wr_i || !tag_full);

`ifdef MEM_ARB_RR_EN
  mem_client_t last_q;
  // Remember the last accepted client so ties alternate.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        last_q <= MEM_CLIENT_IC;
    else if (accept) last_q <= sel_cl;
  end
  assign tie_cl = (last_q == MEM_CLIENT_IC) ? MEM_CLIENT_DC : MEM_CLIENT_IC;
`else
  assign tie_cl = MEM_CLIENT_DC;
`endif

  // FSM next state and bus drive; the bus is quiet while reset is asserted.
  always_comb begin
    state_d = state_q;
    sel_vld = 1'b0;
    sel_cl  = MEM_CLIENT_IC;
    cmd     = BUS_NONE;
    addr    = '0;
    data    = '0;
    if (state_q == HOLD) begin
      sel_vld = 1'b1;
      sel_cl  = hold_cl_q;
      cmd     = hold_cmd_q;
      addr    = hold_addr_q;
      data    = hold_data_q;
    end else if (ic_ok || dc_ok) begin
      sel_vld = 1'b1;
      sel_cl  = (ic_ok && dc_ok) ? tie_cl : (dc_ok ? MEM_CLIENT_DC : MEM_CLIENT_IC);
      if (sel_cl == MEM_CLIENT_DC) begin
        cmd  = dc_wr_i ? BUS_STORE : BUS_LOAD;
        addr = dc_addr_i;
        data = dc_wr_i ? dc_wdata_i : '0;
      end else begin
        cmd  = BUS_LOAD;
        addr = ic_addr_i;
      end
    end
    if (!rst) begin
      sel_vld = 1'b0;
      cmd     = BUS_NONE;
      addr    = '0;
      data    = '0;
    end
    accept = sel_vld && (mem2proc_response_i != '0);
    if (sel_vld) state_d = accept ? IDLE : HOLD;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Capture the refused winner so HOLD replays it unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_cl_q   <= MEM_CLIENT_IC;
      hold_cmd_q  <= BUS_NONE;
      hold_addr_q <= '0;
      hold_data_q <= '0;
    end else if (state_q == IDLE && state_d == HOLD) begin
      hold_cl_q   <= sel_cl;
      hold_cmd_q  <= cmd;
      hold_addr_q <= addr;
      hold_data_q <= data;
    end
  end

  assign proc2mem_command_o = cmd;
  assign proc2mem_addr_o    = addr;
  assign proc2mem_data_o    = data;

  assign ic_ack_o     = accept && (sel_cl == MEM_CLIENT_IC);
  assign dc_ack_o     = accept && (sel_cl == MEM_CLIENT_DC);
  assign ic_ack_tag_o = ic_ack_o ? mem2proc_response_i : '0;
  assign dc_ack_tag_o = (dc_ack_o && cmd == BUS_LOAD) ? mem2proc_response_i : '0;

  mem_tag_table #(.TAG_W(TAG_W), .TAG_NUM(TAG_NUM), .CNT_W(CNT_W)) u_tag_table (
    .clk         (clk),
    .rst         (rst),
    .alloc_en    (accept && cmd == BUS_LOAD),
    .alloc_tag   (mem2proc_response_i),
    .alloc_owner (sel_cl),
    .clr_en      (ret_hit),
    .lk_tag      (mem2proc_tag_i),
    .lk_vld      (lk_vld),
    .lk_owner    (lk_owner),
    .outstanding (outstanding)
  );

  assign ret_hit        = rst && lk_vld;
  assign ic_rdata_vld_o = ret_hit && (lk_owner == MEM_CLIENT_IC);
  assign dc_rdata_vld_o = ret_hit && (lk_owner == MEM_CLIENT_DC);
  assign ic_rdata_o     = ic_rdata_vld_o ? mem2proc_data_i : '0;
  assign dc_rdata_o     = dc_rdata_vld_o ? mem2proc_data_i : '0;
  assign ic_rtag_o      = ic_rdata_vld_o ? mem2proc_tag_i : '0;
  assign dc_rtag_o      = dc_rdata_vld_o ? mem2proc_tag_i : '0;

  // Sticky flag for a return whose tag nobody owns.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                     err_q <= 1'b0;
    else if (mem2proc_tag_i != '0 && !lk_vld)    err_q <= 1'b1;
  end

  assign arb_outstanding_o = outstanding;
  assign arb_err_o         = err_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Scoreboard bench for mem_req_arbiter: expected acks/returns are queued when
// stimulus is driven and checked by a monitor when the DUT pulses them.
module tb_mem_req_arbiter;
  import mem_req_arbiter_pkg::*;

  localparam int ADDR_W = 64, DATA_W = 64, TAG_W = 4;

  logic clk = 1'b0, rst = 1'b0;
  logic ic_req, dc_req, dc_wr;
  logic [ADDR_W-1:0] ic_addr, dc_addr, p_addr;
  logic [DATA_W-1:0] dc_wdata, p_data, mdata, ic_rdata, dc_rdata;
  logic [TAG_W-1:0]  resp, mtag, ic_ack_tag, dc_ack_tag, ic_rtag, dc_rtag;
  logic ic_ack, dc_ack, ic_rvld, dc_rvld, err;
  logic [1:0] p_cmd;
  logic [3:0] outst;

  always #5 clk = ~clk;

  mem_req_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W), .TAG_NUM(15)) dut (
    .clk(clk), .rst(rst),
    .ic_req_i(ic_req), .ic_addr_i(ic_addr), .ic_ack_o(ic_ack), .ic_ack_tag_o(ic_ack_tag),
    .ic_rdata_vld_o(ic_rvld), .ic_rdata_o(ic_rdata), .ic_rtag_o(ic_rtag),
    .dc_req_i(dc_req), .dc_wr_i(dc_wr), .dc_addr_i(dc_addr), .dc_wdata_i(dc_wdata),
    .dc_ack_o(dc_ack), .dc_ack_tag_o(dc_ack_tag), .dc_rdata_vld_o(dc_rvld),
    .dc_rdata_o(dc_rdata), .dc_rtag_o(dc_rtag),
    .proc2mem_command_o(p_cmd), .proc2mem_addr_o(p_addr), .proc2mem_data_o(p_data),
    .mem2proc_response_i(resp), .mem2proc_data_i(mdata), .mem2proc_tag_i(mtag),
    .arb_outstanding_o(outst), .arb_err_o(err)
  );

  typedef struct { logic dc; logic [TAG_W-1:0] tag; } ack_t;
  typedef struct { logic dc; logic [DATA_W-1:0] data; logic [TAG_W-1:0] tag; } ret_t;

  ack_t ack_q[$];
  ret_t ret_q[$];
  ack_t ma;
  ret_t mr;
  logic owner_dc [16];
  logic last_dc, w_dc;
  int   checks = 0, errors = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected winner of a tie under the selected arbitration policy.
  function automatic logic tie_dc();
`ifdef MEM_ARB_RR_EN
    return !last_dc;
`else
    return 1'b1;
`endif
  endfunction

  task automatic exp_ack(logic dc, logic [TAG_W-1:0] tag, logic ld);
    ack_t a;
    a.dc  = dc;
    a.tag = ld ? tag : '0;
    ack_q.push_back(a);
    if (ld) owner_dc[tag] = dc;
    last_dc = dc;
  endtask

  task automatic ret(logic [TAG_W-1:0] t, logic [DATA_W-1:0] d);
    ret_t r;
    r.dc = owner_dc[t]; r.data = d; r.tag = t;
    ret_q.push_back(r);
    mtag  = t;
    mdata = d;
  endtask

  // Advance one cycle and return every input to its idle value.
  task automatic cyc();
    @(posedge clk); #1;
    ic_req = 0; dc_req = 0; dc_wr = 0; resp = '0; mtag = '0; mdata = '0;
  endtask

  // Monitor: every ack / return pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      if (ic_ack || dc_ack) begin
        chk("ack_both", 64'(ic_ack && dc_ack), 0);
        if (ack_q.size() == 0) chk("ack_spurious", 1, 0);
        else begin
          ma = ack_q.pop_front();
          chk("ack_client", 64'(dc_ack), 64'(ma.dc));
          chk("ack_tag", 64'(dc_ack ? dc_ack_tag : ic_ack_tag), 64'(ma.tag));
        end
      end
      if (ic_rvld || dc_rvld) begin
        if (ret_q.size() == 0) chk("ret_spurious", 1, 0);
        else begin
          mr = ret_q.pop_front();
          chk("ret_client", 64'(dc_rvld), 64'(mr.dc));
          chk("ret_data", dc_rvld ? dc_rdata : ic_rdata, mr.data);
          chk("ret_tag", 64'(dc_rvld ? dc_rtag : ic_rtag), 64'(mr.tag));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    ic_req = 1; ic_addr = 64'h100; dc_req = 0; dc_wr = 0; dc_addr = '0; dc_wdata = '0;
    resp = '0; mtag = '0; mdata = '0; last_dc = 0;
    for (int i = 0; i < 16; i++) owner_dc[i] = 0;
    #2;
    chk("rst_cmd", 64'(p_cmd), 64'(BUS_NONE));
    chk("rst_ack", 64'(ic_ack), 0);
    chk("rst_outst", 64'(outst), 0);
    chk("rst_err", 64'(err), 0);
    repeat (2) @(posedge clk);
    #1; rst = 1; ic_req = 0;

    // icache load accepted same cycle, later returned
    cyc; ic_req = 1; ic_addr = 64'h100; resp = 4'd3; exp_ack(0, 4'd3, 1);
    @(negedge clk);
    chk("ic_cmd", 64'(p_cmd), 64'(BUS_LOAD));
    chk("ic_addr", p_addr, 64'h100);
    cyc; @(negedge clk); chk("ic_outst1", 64'(outst), 1);
    cyc; ret(4'd3, 64'hDEAD); @(negedge clk);
    cyc; @(negedge clk); chk("ic_outst0", 64'(outst), 0);

    // dcache store refused twice, then accepted
    for (int i = 0; i < 3; i++) begin
      cyc; dc_req = 1; dc_wr = 1; dc_addr = 64'h200; dc_wdata = 64'h55;
      resp = (i == 2) ? 4'd5 : 4'd0;
      if (i == 2) exp_ack(1, 4'd5, 0);
      @(negedge clk);
      chk("st_cmd", 64'(p_cmd), 64'(BUS_STORE));
      chk("st_addr", p_addr, 64'h200);
      chk("st_data", p_data, 64'h55);
      chk("st_ack", 64'(dc_ack), 64'(i == 2));
    end
    cyc; @(negedge clk); chk("st_outst", 64'(outst), 0);

    // no re-arbitration while an icache load is held
    cyc; ic_req = 1; ic_addr = 64'h300; exp_ack(0, 4'd2, 1);
    @(negedge clk); chk("h_addr0", p_addr, 64'h300);
    cyc; ic_req = 1; ic_addr = 64'h300; dc_req = 1; dc_addr = 64'h400;
    @(negedge clk); chk("h_addr1", p_addr, 64'h300);
    cyc; ic_req = 1; ic_addr = 64'h300; dc_req = 1; dc_addr = 64'h400; resp = 4'd2;
    @(negedge clk); chk("h_addr2", p_addr, 64'h300);
    cyc; dc_req = 1; dc_addr = 64'h400; resp = 4'd4; exp_ack(1, 4'd4, 1);
    @(negedge clk); chk("h_dc_addr", p_addr, 64'h400);
    cyc; ret(4'd4, 64'h44); @(negedge clk);
    cyc; ret(4'd2, 64'h22); @(negedge clk);

    // back-to-back dual requests, then icache alone
    for (int k = 0; k < 4; k++) begin
      cyc; ic_req = 1; ic_addr = 64'h600; dc_req = 1; dc_addr = 64'h500;
      resp = TAG_W'(8 + k);
      w_dc = tie_dc();
      exp_ack(w_dc, TAG_W'(8 + k), 1);
      @(negedge clk); chk("tie_addr", p_addr, w_dc ? 64'h500 : 64'h600);
    end
    cyc; ic_req = 1; ic_addr = 64'h600; resp = 4'd12; exp_ack(0, 4'd12, 1);
    @(negedge clk); chk("tie_ic_addr", p_addr, 64'h600);
    for (int t = 8; t <= 12; t++) begin
      cyc; ret(TAG_W'(t), 64'hB0 + 64'(t)); @(negedge clk);
    end
    cyc; @(negedge clk); chk("tie_outst", 64'(outst), 0);

    // fill every tag
    for (int t = 1; t <= 15; t++) begin
      cyc; ic_req = 1; ic_addr = 64'(t * 16); resp = TAG_W'(t); exp_ack(0, TAG_W'(t), 1);
      @(negedge clk); chk("fill_cmd", 64'(p_cmd), 64'(BUS_LOAD));
    end
    cyc; ic_req = 1; ic_addr = 64'h1000;
    @(negedge clk);
    chk("full_outst", 64'(outst), 15);
    chk("full_cmd", 64'(p_cmd), 64'(BUS_NONE));
    chk("full_ack", 64'(ic_ack), 0);
    cyc; ic_req = 1; ic_addr = 64'h1000; dc_req = 1; dc_wr = 1; dc_addr = 64'h700;
    dc_wdata = 64'h77; resp = 4'd1; exp_ack(1, 4'd1, 0);
    @(negedge clk); chk("full_st_cmd", 64'(p_cmd), 64'(BUS_STORE));
    cyc; ic_req = 1; ic_addr = 64'h1000; ret(4'd7, 64'h707);
    @(negedge clk); chk("full_ret_cmd", 64'(p_cmd), 64'(BUS_NONE));
    cyc; ic_req = 1; ic_addr = 64'h1000; resp = 4'd7; exp_ack(0, 4'd7, 1);
    @(negedge clk);
    chk("unblk_cmd", 64'(p_cmd), 64'(BUS_LOAD));
    chk("unblk_addr", p_addr, 64'h1000);
    cyc; ret(4'd5, 64'h505); @(negedge clk);
    // same-cycle return and allocate of one tag
    cyc; ret(4'd6, 64'h606); dc_req = 1; dc_addr = 64'h800; resp = 4'd6; exp_ack(1, 4'd6, 1);
    @(negedge clk); chk("same_cmd", 64'(p_cmd), 64'(BUS_LOAD));
    cyc; @(negedge clk); chk("same_outst", 64'(outst), 14);
    for (int t = 1; t <= 15; t++) begin
      if (t != 5) begin
        cyc; ret(TAG_W'(t), 64'hA000 + 64'(t)); @(negedge clk);
      end
    end
    cyc; @(negedge clk); chk("drain_outst", 64'(outst), 0);

    // return with unowned tag
    cyc; mtag = 4'd9; mdata = 64'h99;
    @(negedge clk);
    chk("err_ic_vld", 64'(ic_rvld), 0);
    chk("err_dc_vld", 64'(dc_rvld), 0);
    for (int i = 0; i < 3; i++) begin
      cyc; @(negedge clk); chk("err_sticky", 64'(err), 1);
    end

    // reset while holding and with a load in flight
    cyc; ic_req = 1; ic_addr = 64'h900; resp = 4'd2; exp_ack(0, 4'd2, 1);
    @(negedge clk);
    cyc; ic_req = 1; ic_addr = 64'hA00;
    @(negedge clk);
    cyc; ic_req = 1; ic_addr = 64'hA00;
    @(negedge clk); chk("hold_pre_rst", p_addr, 64'hA00);
    rst = 0; #1;
    chk("mid_rst_cmd", 64'(p_cmd), 64'(BUS_NONE));
    chk("mid_rst_err", 64'(err), 0);
    chk("mid_rst_outst", 64'(outst), 0);
    cyc; last_dc = 0; rst = 1;
    cyc; mtag = 4'd2; mdata = 64'h222;
    @(negedge clk); chk("late_vld", 64'(ic_rvld), 0);
    cyc; @(negedge clk); chk("late_err", 64'(err), 1);

    chk("ackq_empty", 64'(ack_q.size()), 0);
    chk("retq_empty", 64'(ret_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
